// File: rtl/ram_req_ctrl_if.sv
// Command/response bundle between a requester and ram_req_ctrl.
//   cmd_valid/cmd_ready : command handshake, accepted when both high at posedge clk
//   cmd_write           : 1 = write, 0 = read
//   cmd_addr/cmd_wdata  : target address and write data
//   rsp_valid/rsp_data  : one-cycle read response pulse; rsp_data holds until the next pulse
// master = requester side, slave = controller side.
interface ram_req_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request controller in front of a single-port RAM.
// Buffers read/write commands in a DEPTH-entry FIFO and issues the head on the RAM pins,
// inserting one turnaround cycle between a read issue and a following write so the RAM's
// read data and our write data never collide on the shared bus.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   cmd              : command/response interface (slave modport)
//   err              : sticky protocol error (rd_valid without an outstanding read, or missing)
//   ram_address      : RAM address, head address while issuing, else 0
//   ram_data         : shared bus, driven only in write-issue cycles, else high-Z
//   ram_rd_req/wr_req: RAM request strobes, never both high
//   ram_rd_valid     : RAM read data valid, one cycle after ram_rd_req
module ram_req_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    ram_req_ctrl_if.slave     cmd,
    output logic              err,
    output logic [ADDR_W-1:0] ram_address,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_rd_req,
    output logic              ram_wr_req,
    input  logic              ram_rd_valid
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StTurn} state_e;

    // FIFO storage (no reset needed, validity tracked by count_q)
    logic              fifo_write_q [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   count_q;
    // state_q is what was issued last cycle; state_d is what is issued this cycle
    state_e           state_q, state_d;
    logic             expect_q;
    logic             first_q;   // first cycle after reset release, stray rd_valid ignored
    logic             rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic             err_q;

    logic empty, head_write, push, pop, issue_rd, issue_wr;

    always_comb begin
        empty      = (count_q == '0);
        head_write = fifo_write_q[rd_ptr_q];
        state_d    = StIdle;
        if (!empty) begin
            if (head_write) begin
                // RAM owns the bus in the cycle after a read issue
                state_d = (state_q == StRead) ? StTurn : StWrite;
            end else begin
                state_d = StRead;
            end
        end
        issue_rd = (state_d == StRead);
        issue_wr = (state_d == StWrite);
        pop      = issue_rd || issue_wr;
        push     = cmd.cmd_valid && cmd.cmd_ready;
    end

    assign cmd.cmd_ready = (count_q != CNT_FULL);
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;
    assign err           = err_q;
    assign ram_rd_req    = issue_rd;
    assign ram_wr_req    = issue_wr;
    assign ram_address   = pop ? fifo_addr_q[rd_ptr_q] : '0;
    assign ram_data      = issue_wr ? fifo_wdata_q[rd_ptr_q] : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= cmd.cmd_write;
            fifo_addr_q[wr_ptr_q]  <= cmd.cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd.cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            expect_q    <= 1'b0;
            first_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (!push && pop) begin
                count_q <= count_q - CNT_ONE;
            end
            state_q     <= state_d;
            expect_q    <= issue_rd;
            first_q     <= 1'b0;
            rsp_valid_q <= ram_rd_valid && expect_q;
            if (ram_rd_valid && expect_q) begin
                rsp_data_q <= ram_data;
            end
            if ((ram_rd_valid && !expect_q && !first_q) || (expect_q && !ram_rd_valid)) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_req_ctrl.sv
module tb_ram_req_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wire  [DW-1:0] ram_data;
    wire           ram_rd_valid;
    logic [AW-1:0] ram_address;
    logic          ram_rd_req, ram_wr_req, err;

    ram_req_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (bus),
        .err          (err),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_rd_req   (ram_rd_req),
        .ram_wr_req   (ram_wr_req),
        .ram_rd_valid (ram_rd_valid)
    );

    // RAM model: write commits at end of issue cycle, read data one cycle after rd_req
    logic [DW-1:0] mem [256];
    logic          rd_pend = 1'b0;
    logic [DW-1:0] rd_q = '0;
    logic          stray = 1'b0;
    always @(posedge clk) begin
        if (ram_wr_req) mem[ram_address] <= ram_data;
        rd_pend <= ram_rd_req;
        rd_q    <= mem[ram_address];
    end
    assign ram_rd_valid = rd_pend | stray;
    assign ram_data     = rd_pend ? rd_q : {DW{1'bz}};

    // Reference model state
    typedef struct {
        bit          w;
        bit [AW-1:0] a;
        bit [DW-1:0] d;
    } cmd_t;
    cmd_t        pend[$];      // accepted, not yet issued
    bit [DW-1:0] exp_rsp[$];   // scoreboard of expected read data
    int          rdc_q[$];     // cycle numbers of read issues
    bit [DW-1:0] shadow [256];
    bit          prev_rd = 0, after_rst = 0, first_cyc = 0, err_exp = 0;
    int          cyc = 0, ready_low = 0;
    int          checks = 0, passes = 0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        bit issued, exp_issue, exp_now, viol;
        cmd_t h;
        bit [DW-1:0] d;
        cyc++;
        if (rst) begin
            pend.delete();
            exp_rsp.delete();
            rdc_q.delete();
            prev_rd   = 0;
            err_exp   = 0;
            after_rst = 1;
        end else begin
            if (after_rst) begin
                chk("rst_cmd_ready", bus.cmd_ready == 1'b1, 32'(bus.cmd_ready), 1);
                chk("rst_rsp_valid", bus.rsp_valid == 1'b0, 32'(bus.rsp_valid), 0);
                chk("rst_rsp_data", bus.rsp_data == '0, 32'(bus.rsp_data), 0);
                chk("rst_err", err == 1'b0, 32'(err), 0);
                chk("rst_rd_req", ram_rd_req == 1'b0, 32'(ram_rd_req), 0);
                chk("rst_wr_req", ram_wr_req == 1'b0, 32'(ram_wr_req), 0);
                chk("rst_address", ram_address == '0, 32'(ram_address), 0);
                // flushed writes never reached the RAM
                for (int i = 0; i < 256; i++) shadow[i] = mem[i];
                first_cyc = 1;
                after_rst = 0;
            end
            chk("err", err == err_exp, 32'(err), 32'(err_exp));
            chk("cmd_ready", bus.cmd_ready == (pend.size() < DEPTH), 32'(bus.cmd_ready),
                32'(pend.size() < DEPTH));
            chk("rd_wr_excl", !(ram_rd_req && ram_wr_req), {ram_rd_req, ram_wr_req}, 0);
            chk("bus_clash", !(ram_wr_req && ram_rd_valid), {ram_wr_req, ram_rd_valid}, 0);

            issued    = ram_rd_req || ram_wr_req;
            exp_issue = (pend.size() > 0) && !(prev_rd && pend[0].w);
            chk("issue", issued == exp_issue, 32'(issued), 32'(exp_issue));
            if (issued && pend.size() > 0) begin
                h = pend.pop_front();
                chk("issue_kind", ram_wr_req == h.w, 32'(ram_wr_req), 32'(h.w));
                chk("issue_addr", ram_address == h.a, 32'(ram_address), 32'(h.a));
                if (h.w) chk("issue_wdata", ram_data == h.d, 32'(ram_data), 32'(h.d));
                else rdc_q.push_back(cyc);
            end

            exp_now = (rdc_q.size() > 0) && (rdc_q[0] + 2 == cyc);
            chk("rsp_valid", bus.rsp_valid == exp_now, 32'(bus.rsp_valid), 32'(exp_now));
            if (exp_now) begin
                void'(rdc_q.pop_front());
                if (exp_rsp.size() > 0) begin
                    d = exp_rsp.pop_front();
                    if (bus.rsp_valid)
                        chk("rsp_data", bus.rsp_data == d, 32'(bus.rsp_data), 32'(d));
                end
            end

            viol = (ram_rd_valid && !prev_rd && !first_cyc) || (prev_rd && !ram_rd_valid);
            if (viol) err_exp = 1;
            first_cyc = 0;
            prev_rd   = ram_rd_req;
            if (!bus.cmd_ready) ready_low++;

            if (bus.cmd_valid && bus.cmd_ready) begin
                h.w = bus.cmd_write;
                h.a = bus.cmd_addr;
                h.d = bus.cmd_wdata;
                pend.push_back(h);
                if (h.w) shadow[h.a] = h.d;
                else exp_rsp.push_back(shadow[h.a]);
            end
        end
    end

    task automatic push_cmd(input bit w, input bit [AW-1:0] a, input bit [DW-1:0] d);
        bit acc;
        int guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        forever begin
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 50) begin
                chk("accept_timeout", 1'b0, 32'(guard), 50);
                break;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = DW'($urandom);
            shadow[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // write then read back
        push_cmd(1'b1, 8'h12, 16'hBEEF);
        push_cmd(1'b0, 8'h12, 16'h0);
        idle(6);
        chk("beef_readback", bus.rsp_data == 16'hBEEF, 32'(bus.rsp_data), 32'hBEEF);

        // preload then four back-to-back reads
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 8'(i), 16'hA0 + 16'(i));
        idle(2);
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 8'(i), 16'h0);
        idle(6);
        chk("seq_last", bus.rsp_data == 16'hA3, 32'(bus.rsp_data), 32'hA3);

        // read / write / read with turnaround
        push_cmd(1'b0, 8'h05, 16'h0);
        push_cmd(1'b1, 8'h06, 16'h1234);
        push_cmd(1'b0, 8'h06, 16'h0);
        idle(6);
        chk("turn_readback", bus.rsp_data == 16'h1234, 32'(bus.rsp_data), 32'h1234);

        // alternating reads/writes outrun the issue rate and fill the FIFO
        ready_low = 0;
        for (int i = 0; i < 16; i++) push_cmd(i[0], 8'($urandom_range(0, 7)), 16'($urandom));
        idle(8);
        chk("fifo_fills", ready_low > 0, 32'(ready_low), 1);

        // randomized traffic on a small address window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            push_cmd(1'($urandom), 8'($urandom_range(0, 7)), 16'($urandom));
        end
        idle(8);

        // reset in the cycle the read data is due, then a stray rd_valid right after
        push_cmd(1'b0, 8'h20, 16'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        idle(6);

        // stray rd_valid with nothing outstanding sets the sticky error
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        idle(5);
        chk("err_sticky", err == 1'b1, 32'(err), 1);

        chk("drain", pend.size() == 0 && exp_rsp.size() == 0,
            32'(pend.size() + exp_rsp.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
